// File: rtl/watermark_pkg.sv
// Shared definitions for the watermarking core register bank: address map,
// CTRL bit positions and the APB slave state encoding.
package watermark_pkg;

   localparam int unsigned ADDR_CTRL     = 32'h00;
   localparam int unsigned ADDR_WHITE    = 32'h01;
   localparam int unsigned ADDR_PSIZE    = 32'h02;
   localparam int unsigned ADDR_WSIZE    = 32'h03;
   localparam int unsigned ADDR_BSIZE    = 32'h04;
   localparam int unsigned ADDR_EDGE     = 32'h05;
   localparam int unsigned ADDR_AMIN     = 32'h06;
   localparam int unsigned ADDR_AMAX     = 32'h07;
   localparam int unsigned ADDR_BMIN     = 32'h08;
   localparam int unsigned ADDR_BMAX     = 32'h09;
   localparam int unsigned ADDR_PIX_BASE = 32'h0A;

   localparam int CTRL_START = 0;
   localparam int CTRL_DONE  = 1;

   localparam int unsigned WHITE_RESET = 32'd255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

endpackage

// File: rtl/regbank_mem.sv
// Word array with one write port and two registered read ports; a read and a
// write to the same word in one cycle return the previous contents.
module regbank_mem #(
   parameter int Width = 16,
   parameter int Depth = 1036810,
   parameter int Index = 20
) (
   input  logic             clk,
   input  logic             we,
   input  logic [Index-1:0] waddr,
   input  logic [Width-1:0] wdata,
   input  logic             rd_en_a,
   input  logic [Index-1:0] raddr_a,
   output logic [Width-1:0] rdata_a,
   input  logic             rd_en_b,
   input  logic [Index-1:0] raddr_b,
   output logic [Width-1:0] rdata_b
);

   logic [Width-1:0] mem [Depth];

   // Read ports hold their last word while their enable is low.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (rd_en_a)
         rdata_a <= mem[raddr_a];
      if (rd_en_b)
         rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank for the watermarking core: CTRL and WhitePixel in
// flops, configuration and pixel words in regbank_mem, plus a core read port.
module apb_slave_regbank
   import watermark_pkg::*;
#(
   parameter int Amba_Word       = 16,
   parameter int Amba_Addr_Depth = 20,
   parameter int Num_Words       = 2*720*720+10,
   parameter int Wait_States     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [Amba_Addr_Depth:0] paddr,
   input  logic [Amba_Word-1:0]     pwdata,
   output logic [Amba_Word-1:0]     prdata,
   output logic                     pready,
   output logic                     pslverr,
   input  logic                     core_rd_en,
   input  logic [Amba_Addr_Depth:0] core_addr,
   output logic [Amba_Word-1:0]     core_rd_data,
   input  logic                     done,
   output logic                     start
);

   localparam int AW = Amba_Addr_Depth + 1;
   localparam int IW = $clog2(Num_Words);
   localparam logic [AW-1:0] LIMIT      = AW'(Num_Words);
   localparam logic [AW-1:0] A_CTRL     = AW'(ADDR_CTRL);
   localparam logic [AW-1:0] A_WHITE    = AW'(ADDR_WHITE);
   localparam logic [AW-1:0] A_MEM_BASE = AW'(ADDR_PSIZE);
   localparam logic [2:0]    WAIT_LOAD  = 3'(Wait_States);

   apb_state_t state, next_state, phase;
   logic [2:0] wait_cnt, next_cnt;
   logic xfer_done;

   logic start_q, done_q;
   logic [Amba_Word-1:0] white_q, ctrl_word;

   logic p_oor, p_is_ctrl, p_is_white, p_in_mem;
   logic c_oor, c_is_ctrl, c_is_white, c_in_mem;
   logic wr_reject, wr_ok, ctrl_wr, white_wr, mem_we;

   logic apb_use_mem, core_use_mem;
   logic [Amba_Word-1:0] apb_word, core_word, mem_rdata_a, mem_rdata_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;
      end
   end

   // The setup phase is the IDLE cycle in which the master presents psel
   // without penable, so a zero-wait transfer completes in its second cycle.
   always_comb begin
      phase      = state;
      next_state = state;
      next_cnt   = wait_cnt;
      xfer_done  = 1'b0;
      if (state == ST_IDLE && psel && !penable)
         phase = ST_SETUP;
      case (phase)
         ST_IDLE:   next_state = ST_IDLE;
         ST_SETUP: begin
            next_state = ST_ACCESS;
            next_cnt   = WAIT_LOAD;
         end
         ST_ACCESS: begin
            if (!psel || !penable)
               next_state = ST_IDLE;
            else if (wait_cnt != 3'd0)
               next_cnt = wait_cnt - 3'd1;
            else begin
               xfer_done  = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default:   next_state = ST_IDLE;
      endcase
   end

   assign pready = xfer_done;

   assign p_oor      = (paddr >= LIMIT);
   assign p_is_ctrl  = (paddr == A_CTRL);
   assign p_is_white = (paddr == A_WHITE);
   assign p_in_mem   = !p_oor && (paddr >= A_MEM_BASE);

   assign c_oor      = (core_addr >= LIMIT);
   assign c_is_ctrl  = (core_addr == A_CTRL);
   assign c_is_white = (core_addr == A_WHITE);
   assign c_in_mem   = !c_oor && (core_addr >= A_MEM_BASE);

   // Data words are frozen while the core runs; CTRL always stays writable.
   assign wr_reject = pwrite && !p_oor && !p_is_ctrl && start_q;
   assign pslverr   = xfer_done && (p_oor || wr_reject);
   assign wr_ok     = xfer_done && pwrite && !p_oor && !wr_reject;
   assign ctrl_wr   = wr_ok && p_is_ctrl;
   assign white_wr  = wr_ok && p_is_white;
   assign mem_we    = wr_ok && p_in_mem;

   // A done pulse overrides a CTRL write landing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         white_q <= Amba_Word'(WHITE_RESET);
      end else begin
         if (done) begin
            start_q <= 1'b0;
            done_q  <= 1'b1;
         end else if (ctrl_wr) begin
            start_q <= pwdata[CTRL_START];
            done_q  <= 1'b0;
         end
         if (white_wr)
            white_q <= pwdata;
      end
   end

   assign start = start_q;

   always_comb begin
      ctrl_word             = '0;
      ctrl_word[CTRL_START] = start_q;
      ctrl_word[CTRL_DONE]  = done_q;
   end

   // Flop-held words are captured alongside the array read so both ports
   // see a consistent one-cycle read latency and read-before-write order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         apb_use_mem  <= 1'b0;
         apb_word     <= '0;
         core_use_mem <= 1'b0;
         core_word    <= '0;
      end else begin
         if (psel) begin
            apb_use_mem <= p_in_mem;
            apb_word    <= p_is_ctrl ? ctrl_word : (p_is_white ? white_q : '0);
         end
         if (core_rd_en) begin
            core_use_mem <= c_in_mem;
            core_word    <= c_is_ctrl ? ctrl_word : (c_is_white ? white_q : '0);
         end
      end
   end

   assign prdata       = apb_use_mem  ? mem_rdata_a : apb_word;
   assign core_rd_data = core_use_mem ? mem_rdata_b : core_word;

   regbank_mem #(
      .Width (Amba_Word),
      .Depth (Num_Words),
      .Index (IW)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (paddr[IW-1:0]),
      .wdata   (pwdata),
      .rd_en_a (psel && p_in_mem),
      .raddr_a (paddr[IW-1:0]),
      .rdata_a (mem_rdata_a),
      .rd_en_b (core_rd_en && c_in_mem),
      .raddr_b (core_addr[IW-1:0]),
      .rdata_b (mem_rdata_b)
   );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (0 and 3 wait states), directed
// steps followed by random traffic checked against an address-keyed model.
module tb_apb_slave_regbank;

   localparam int NUM = 2*720*720+10;

   logic clk = 1'b0;
   logic rst;

   logic        psel [2];
   logic        penable [2];
   logic        pwrite [2];
   logic [20:0] paddr [2];
   logic [15:0] pwdata [2];
   logic [15:0] prdata [2];
   logic        pready [2];
   logic        pslverr [2];
   logic        core_rd_en [2];
   logic [20:0] core_addr [2];
   logic [15:0] core_rd_data [2];
   logic        done [2];
   logic        start [2];

   int checks = 0;
   int errors = 0;

   bit [15:0] model [int];
   bit        m_start [2];
   bit        m_done [2];

   always #5 clk = ~clk;

   apb_slave_regbank #(.Amba_Word(16), .Amba_Addr_Depth(20), .Num_Words(NUM), .Wait_States(0)) dut0 (
      .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
      .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
      .pslverr(pslverr[0]), .core_rd_en(core_rd_en[0]), .core_addr(core_addr[0]),
      .core_rd_data(core_rd_data[0]), .done(done[0]), .start(start[0]));

   apb_slave_regbank #(.Amba_Word(16), .Amba_Addr_Depth(20), .Num_Words(NUM), .Wait_States(3)) dut3 (
      .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
      .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
      .pslverr(pslverr[1]), .core_rd_en(core_rd_en[1]), .core_addr(core_addr[1]),
      .core_rd_data(core_rd_data[1]), .done(done[1]), .start(start[1]));

   function automatic int key(input int d, input int a);
      return d * (1 << 22) + a;
   endfunction

   function automatic int ws(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic after_reset();
      for (int d = 0; d < 2; d++) begin
         m_start[d] = 1'b0;
         m_done[d]  = 1'b0;
         model[key(d, 1)] = 16'd255;
      end
   endtask

   // One complete APB transfer; lat is the access-phase cycle carrying pready, -1 on timeout.
   task automatic apb_transfer(input int d, input bit wr, input logic [20:0] a, input logic [15:0] wd,
                               output logic [15:0] rd, output logic err, output int lat);
      @(posedge clk); #1;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      lat = 1;
      while (1) begin
         @(negedge clk);
         if (pready[d] === 1'b1 || lat >= 20) break;
         @(posedge clk); #1;
         lat++;
      end
      if (pready[d] !== 1'b1) lat = -1;
      rd  = prdata[d];
      err = pslverr[d];
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
      @(negedge clk);
      check_output("pready_single_cycle", 32'(pready[d]), 32'd0);
   endtask

   task automatic model_write(input int d, input int a, input logic [15:0] wd);
      logic [15:0] rd;
      logic err;
      int lat;
      bit exp_err;
      exp_err = (a >= NUM) || (a != 0 && m_start[d]);
      apb_transfer(d, 1'b1, 21'(a), wd, rd, err, lat);
      check_output("write_latency", 32'(lat), 32'(ws(d) + 1));
      check_output("write_pslverr", 32'(err), 32'(exp_err));
      if (a < NUM) begin
         if (a == 0) begin
            m_start[d] = wd[0];
            m_done[d]  = 1'b0;
         end else if (!m_start[d]) begin
            model[key(d, a)] = wd;
         end
      end
      check_output("start_pin", 32'(start[d]), 32'(m_start[d]));
   endtask

   function automatic bit expected_word(input int d, input int a, output logic [15:0] v);
      v = 16'h0000;
      if (a >= NUM) return 1'b1;
      if (a == 0) begin
         v = {14'b0, m_done[d], m_start[d]};
         return 1'b1;
      end
      if (model.exists(key(d, a))) begin
         v = model[key(d, a)];
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_read(input int d, input int a);
      logic [15:0] rd, exp_v;
      logic err;
      int lat;
      bit known;
      known = expected_word(d, a, exp_v);
      apb_transfer(d, 1'b0, 21'(a), 16'h0, rd, err, lat);
      check_output("read_latency", 32'(lat), 32'(ws(d) + 1));
      check_output("read_pslverr", 32'(err), 32'(a >= NUM));
      if (known) check_output("read_data", 32'(rd), 32'(exp_v));
   endtask

   task automatic model_done(input int d);
      @(posedge clk); #1;
      done[d] = 1'b1;
      @(posedge clk); #1;
      done[d] = 1'b0;
      m_start[d] = 1'b0;
      m_done[d]  = 1'b1;
      check_output("start_after_done", 32'(start[d]), 32'd0);
   endtask

   task automatic model_core_read(input int d, input int a);
      logic [15:0] exp_v;
      bit known;
      known = expected_word(d, a, exp_v);
      @(posedge clk); #1;
      core_rd_en[d] = 1'b1; core_addr[d] = 21'(a);
      @(posedge clk); #1;
      core_rd_en[d] = 1'b0;
      if (known) check_output("core_read", 32'(core_rd_data[d]), 32'(exp_v));
      @(posedge clk); #1;
      if (known) check_output("core_hold", 32'(core_rd_data[d]), 32'(exp_v));
   endtask

   initial begin
      logic [15:0] rd, old_core;
      logic err;
      int lat, d, a, op;
      int pool[$];

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
         core_rd_en[i] = 1'b0; core_addr[i] = '0; done[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      after_reset();
      $display("[TB] reset released");

      check_output("reset_pready", 32'(pready[0]), 32'd0);
      check_output("reset_prdata", 32'(prdata[1]), 32'd0);
      check_output("reset_core_data", 32'(core_rd_data[0]), 32'd0);
      check_output("reset_start", 32'(start[1]), 32'd0);

      model_read(0, 0);
      model_read(0, 1);

      model_write(1, 'h0A, 16'h1234);
      model_read(1, 'h0A);
      model_core_read(1, 'h0A);

      model_write(1, NUM, 16'hDEAD);
      model_read(1, NUM);
      model_write(1, 'h10000A, 16'hBEEF);
      model_read(1, 'h0A);
      model_core_read(1, NUM);

      model_write(1, 2, 16'h1111);
      model_write(1, 0, 16'h0001);
      model_write(1, 2, 16'h0050);
      model_read(1, 2);
      model_done(1);
      model_read(1, 0);

      fork
         apb_transfer(0, 1'b1, 21'h0, 16'h0001, rd, err, lat);
         begin
            repeat (2) @(posedge clk);
            #1 done[0] = 1'b1;
            @(posedge clk);
            #1 done[0] = 1'b0;
         end
      join
      m_start[0] = 1'b0;
      m_done[0]  = 1'b1;
      check_output("done_vs_write_err", 32'(err), 32'd0);
      check_output("done_vs_write_start", 32'(start[0]), 32'd0);
      model_read(0, 0);
      model_write(0, 0, 16'h0000);
      model_read(0, 0);

      model_write(0, 'h0B, 16'h0AAA);
      fork
         apb_transfer(0, 1'b1, 21'h0B, 16'h0BBB, rd, err, lat);
         begin
            repeat (2) @(posedge clk);
            #1 core_rd_en[0] = 1'b1; core_addr[0] = 21'h0B;
            @(posedge clk);
            #1 core_rd_en[0] = 1'b0;
            old_core = core_rd_data[0];
         end
      join
      model[key(0, 'h0B)] = 16'h0BBB;
      check_output("read_before_write", 32'(old_core), 32'h0AAA);
      model_read(0, 'h0B);

      model_write(1, 0, 16'h0001);
      @(posedge clk); #1;
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 21'h0A;
      @(posedge clk); #1;
      penable[1] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_output("reset_mid_pready", 32'(pready[1]), 32'd0);
      check_output("reset_mid_start", 32'(start[1]), 32'd0);
      @(posedge clk); #1;
      psel[1] = 1'b0; penable[1] = 1'b0;
      rst = 1'b0;
      after_reset();
      model_read(1, 0);
      model_read(1, 1);
      model_read(1, 'h0A);
      model_read(0, 'h0B);

      pool = '{2, 3, 9, 10, 11, 100, NUM - 1};
      for (int dd = 0; dd < 2; dd++)
         foreach (pool[i]) model_write(dd, pool[i], 16'($urandom));
      pool.push_back(0);
      pool.push_back(1);
      pool.push_back(NUM);
      pool.push_back(NUM + 7);
      pool.push_back(21'h1FFFFF);

      for (int n = 0; n < 200; n++) begin
         d  = int'($urandom_range(0, 1));
         a  = pool[$urandom_range(0, pool.size() - 1)];
         op = int'($urandom_range(0, 9));
         if (op <= 3)      model_write(d, a, 16'($urandom));
         else if (op <= 6) model_read(d, a);
         else if (op == 7) model_done(d);
         else              model_core_read(d, a);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
Second-generation register bank for the watermarking core, reached through a standard AMBA APB slave interface with setup/access phases, programmable wait states, PREADY/PSLVERR and an out-of-range address check. It keeps the established map: CTRL 0x00, WhitePixel 0x01, config registers 0x02–0x09, pixels from 0x0A. It adds a second, read-only core-side port with registered reads, and a CTRL start/done handshake with the processing core.

Parameters:
Amba_Word, 16, data register width (bits)
Amba_Addr_Depth, 20, APB address width is Amba_Addr_Depth+1 bits
Num_Words, 2*720*720+10, number of implemented words; addresses >= Num_Words are out of range
Wait_States, 0, extra access-phase cycles before PREADY asserts (0..7)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  Amba_Addr_Depth+1  word address
pwdata  in  Amba_Word  write data
prdata  out  Amba_Word  read data, valid when pready=1
pready  out  1  transfer complete
pslverr  out  1  error response, valid when pready=1
core_rd_en  in  1  core read request
core_addr  in  Amba_Addr_Depth+1  core read address
core_rd_data  out  Amba_Word  core read data, one cycle after core_rd_en
done  in  1  one-cycle pulse from core: processing finished
start  out  1  CTRL[0]; core runs while high

Behaviour:
- Reset: prdata=0, pready=0, pslverr=0, core_rd_data=0, FSM=IDLE, wait counter=0. CTRL=0x0000. WhitePixel=255. Other words are not reset.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel & !penable.
  - SETUP -> ACCESS on the next cycle; wait counter loads Wait_States.
  - ACCESS: decrement the counter while it is non-zero. When it is 0, drive pready=1 for exactly one cycle and perform the transfer in that cycle.
  - After completion: go to SETUP if psel & !penable, otherwise IDLE.
- Protocol error: psel dropping, or penable low, during ACCESS aborts the transfer, returns to IDLE and changes no register. Nothing is flagged; this is a bench assertion only.
- Range check: paddr >= Num_Words gives pslverr=1 together with pready. A write is discarded; a read returns prdata=0.
- Write, address 0x00 (CTRL):
  - bit0 sets start; writing 0 stops the core.
  - Any CTRL write clears the sticky done bit CTRL[1].
  - Bits [15:2] are stored as 0.
- Write, other in-range address: stored as-is.
- Read: prdata = the word's value. CTRL reads as {14'b0, done_flag, start}.
- Data registers (0x01 upward) are writable only while start=0. A write to them with start=1 is rejected with pslverr=1. CTRL stays writable at all times.
- done pulse: clears CTRL[0] and sets CTRL[1] in the same cycle.
  - done and a CTRL write in the same cycle: the done effect wins on bit0 and bit1. The written bit0 is ignored.
- Core port:
  - core_rd_data <= mem[core_addr] one cycle after core_rd_en=1; holds its value when core_rd_en=0.
  - Out-of-range core_addr returns 0.
  - Same-cycle core read and APB write to the same address returns the old value (read-before-write).
- Reset asserted mid-transfer: FSM returns to IDLE immediately and pready drops. Memory contents other than CTRL/WhitePixel are kept.

Decomposition:
- Shared package watermark_pkg holds:
  - address constants ADDR_CTRL, ADDR_WHITE, ADDR_PSIZE, ADDR_WSIZE, ADDR_BSIZE, ADDR_EDGE, ADDR_AMIN, ADDR_AMAX, ADDR_BMIN, ADDR_BMAX, ADDR_PIX_BASE=0x0A
  - CTRL bit indices CTRL_START=0, CTRL_DONE=1
  - the APB FSM state enum
- One sub-module: regbank_mem, a 1-write/2-read synchronous word array sized Num_Words with read-before-write semantics. CTRL and WhitePixel are kept as flops in the top level.

Test Plan:
1. Reset, then APB read of 0x00 and 0x01 with Wait_States=0 -> prdata 0x0000 and 0x00FF; pready high in the second cycle of each transfer; pslverr=0.
2. Wait_States=3: write 0x1234 to 0x0A, read it back -> pready asserts 4 cycles after SETUP; prdata=0x1234; core read of 0x0A returns 0x1234 one cycle later.
3. Write paddr=Num_Words -> pslverr=1, memory unchanged. Read of the same address -> prdata=0, pslverr=1.
4. Write CTRL=1 -> start=1. Write 0x0050 to 0x02 -> pslverr=1, 0x02 unchanged. Pulse done -> start=0; CTRL reads 0x0002.
5. done pulse in the same cycle as a CTRL write of 0x0001 -> start=0, CTRL reads 0x0002. A following CTRL write of 0x0000 -> reads 0x0000.
6. Assert rst during an ACCESS wait state -> pready=0, FSM IDLE, CTRL=0, WhitePixel=255; previously written pixel 0x0A still reads 0x1234.
